// File: rtl/fpu_req_seq.sv
// Memory request sequencer: walks a width x height rectangle row-major and issues
// line-sized read and/or write requests. Define FPU_REQ_SEQ_ABORT_EN to add the abort input.
module fpu_req_seq #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DIM_W      = 17,
   parameter int unsigned STRIDE_W   = 19,
   parameter int unsigned LINE_BYTES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                read,
   input  logic                write,
   input  logic [DIM_W-1:0]    width,
   input  logic [DIM_W-1:0]    height,
   input  logic [ADDR_W-1:0]   read_address,
   input  logic [ADDR_W-1:0]   write_address,
   input  logic [STRIDE_W-1:0] input_row_width,
   input  logic [STRIDE_W-1:0] output_row_width,
`ifdef FPU_REQ_SEQ_ABORT_EN
   input  logic                abort,
`endif
   output logic                req_valid,
   input  logic                req_ready,
   output logic                req_we,
   output logic [ADDR_W-1:0]   req_addr,
   output logic                making_request,
   output logic                done
);

   localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);
   localparam int unsigned BEAT_W     = DIM_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                rd_en_q, rd_en_d;
   logic                wr_en_q, wr_en_d;
   logic [BEAT_W-1:0]   beats_q, beats_d;
   logic [DIM_W-1:0]    rows_q, rows_d;
   logic [STRIDE_W-1:0] rd_stride_q, rd_stride_d;
   logic [STRIDE_W-1:0] wr_stride_q, wr_stride_d;
   logic [ADDR_W-1:0]   rd_row_q, rd_row_d;
   logic [ADDR_W-1:0]   wr_row_q, wr_row_d;
   logic [ADDR_W-1:0]   beat_off_q, beat_off_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [DIM_W-1:0]    row_cnt_q, row_cnt_d;
   logic                req_valid_q, req_valid_d;
   logic                req_we_q, req_we_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                cfg_ok;
   logic [BEAT_W-1:0]   beats_calc;
   logic                last_beat;
   logic                last_row;
   logic                accept;
   logic                abort_now;

   // Rounded-up line count per row, evaluated on the raw inputs at launch
   assign beats_calc = BEAT_W'((BEAT_W'(width) + BEAT_W'(LINE_BYTES - 1)) >> LINE_SHIFT);
   assign cfg_ok     = (read | write) && (width != '0) && (height != '0);
   assign last_beat  = (beat_cnt_q == beats_q - BEAT_W'(1));
   assign last_row   = (row_cnt_q == rows_q - DIM_W'(1));
   assign accept     = req_valid_q & req_ready;

`ifdef FPU_REQ_SEQ_ABORT_EN
   logic abort_pend_q, abort_pend_d;
   // An abort seen while a request is stalled waits until that request is accepted
   assign abort_now = (abort | abort_pend_q) && (!req_valid_q || req_ready);
`else
   assign abort_now = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rd_en_d     = rd_en_q;
      wr_en_d     = wr_en_q;
      beats_d     = beats_q;
      rows_d      = rows_q;
      rd_stride_d = rd_stride_q;
      wr_stride_d = wr_stride_q;
      rd_row_d    = rd_row_q;
      wr_row_d    = wr_row_q;
      beat_off_d  = beat_off_q;
      beat_cnt_d  = beat_cnt_q;
      row_cnt_d   = row_cnt_q;
      req_valid_d = req_valid_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
`ifdef FPU_REQ_SEQ_ABORT_EN
      abort_pend_d = abort_pend_q;
`endif

      unique case (state_q)
         IDLE: begin
`ifdef FPU_REQ_SEQ_ABORT_EN
            abort_pend_d = 1'b0;
`endif
            if (start) begin
               rd_en_d     = read;
               wr_en_d     = write;
               beats_d     = beats_calc;
               rows_d      = height;
               rd_stride_d = input_row_width;
               wr_stride_d = output_row_width;
               rd_row_d    = read_address;
               wr_row_d    = write_address;
               beat_off_d  = '0;
               beat_cnt_d  = '0;
               row_cnt_d   = '0;
               if (cfg_ok) begin
                  state_d     = RUN;
                  req_valid_d = 1'b1;
                  req_we_d    = !read;
                  req_addr_d  = read ? read_address : write_address;
               end else begin
                  state_d = DONE;
               end
            end
         end

         RUN: begin
            if (abort_now) begin
               state_d     = DONE;
               req_valid_d = 1'b0;
               req_we_d    = 1'b0;
            end else if (accept) begin
               if (!req_we_q && wr_en_q) begin
                  // Write half of the same beat
                  req_we_d   = 1'b1;
                  req_addr_d = wr_row_q + beat_off_q;
               end else if (!last_beat) begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                  beat_off_d = beat_off_q + ADDR_W'(LINE_BYTES);
                  req_we_d   = !rd_en_q;
                  req_addr_d = (rd_en_q ? rd_row_q : wr_row_q) + beat_off_d;
               end else if (!last_row) begin
                  row_cnt_d  = row_cnt_q + DIM_W'(1);
                  beat_cnt_d = '0;
                  beat_off_d = '0;
                  rd_row_d   = rd_row_q + ADDR_W'(rd_stride_q);
                  wr_row_d   = wr_row_q + ADDR_W'(wr_stride_q);
                  req_we_d   = !rd_en_q;
                  req_addr_d = rd_en_q ? rd_row_d : wr_row_d;
               end else begin
                  state_d     = DONE;
                  req_valid_d = 1'b0;
                  req_we_d    = 1'b0;
               end
            end
`ifdef FPU_REQ_SEQ_ABORT_EN
            if (abort && !abort_now) begin
               abort_pend_d = 1'b1;
            end
`endif
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
            req_we_d    = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         beats_q     <= '0;
         rows_q      <= '0;
         rd_stride_q <= '0;
         wr_stride_q <= '0;
         rd_row_q    <= '0;
         wr_row_q    <= '0;
         beat_off_q  <= '0;
         beat_cnt_q  <= '0;
         row_cnt_q   <= '0;
         req_valid_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef FPU_REQ_SEQ_ABORT_EN
         abort_pend_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         beats_q     <= beats_d;
         rows_q      <= rows_d;
         rd_stride_q <= rd_stride_d;
         wr_stride_q <= wr_stride_d;
         rd_row_q    <= rd_row_d;
         wr_row_q    <= wr_row_d;
         beat_off_q  <= beat_off_d;
         beat_cnt_q  <= beat_cnt_d;
         row_cnt_q   <= row_cnt_d;
         req_valid_q <= req_valid_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef FPU_REQ_SEQ_ABORT_EN
         abort_pend_q <= abort_pend_d;
`endif
      end
   end

   assign req_valid      = req_valid_q;
   assign req_we         = req_we_q;
   assign req_addr       = req_addr_q;
   assign making_request = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_fpu_req_seq.sv
// Directed bench for fpu_req_seq; the abort case is built only with FPU_REQ_SEQ_ABORT_EN.
module tb_fpu_req_seq;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DIM_W    = 17;
   localparam int unsigned STRIDE_W = 19;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                read;
   logic                write;
   logic [DIM_W-1:0]    width;
   logic [DIM_W-1:0]    height;
   logic [ADDR_W-1:0]   read_address;
   logic [ADDR_W-1:0]   write_address;
   logic [STRIDE_W-1:0] input_row_width;
   logic [STRIDE_W-1:0] output_row_width;
   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic                making_request;
   logic                done;
`ifdef FPU_REQ_SEQ_ABORT_EN
   logic                abort;
`endif

   int n_vec = 0;
   int n_err = 0;

   fpu_req_seq dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .read             (read),
      .write            (write),
      .width            (width),
      .height           (height),
      .read_address     (read_address),
      .write_address    (write_address),
      .input_row_width  (input_row_width),
      .output_row_width (output_row_width),
`ifdef FPU_REQ_SEQ_ABORT_EN
      .abort            (abort),
`endif
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_addr         (req_addr),
      .making_request   (making_request),
      .done             (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the presented request, then advance one cycle (accepted when ready=1)
   task automatic expect_req(input string tag, input logic we, input logic [31:0] a);
      chk({tag, " valid"}, 64'(req_valid), 64'd1);
      chk({tag, " we"}, 64'(req_we), 64'(we));
      chk({tag, " addr"}, 64'(req_addr), 64'(a));
      chk({tag, " busy"}, 64'(making_request), 64'd1);
      step();
   endtask

   task automatic expect_done(input string tag);
      chk({tag, " done valid"}, 64'(req_valid), 64'd0);
      chk({tag, " done pulse"}, 64'(done), 64'd1);
      chk({tag, " done busy"}, 64'(making_request), 64'd1);
      step();
      chk({tag, " idle done"}, 64'(done), 64'd0);
      chk({tag, " idle busy"}, 64'(making_request), 64'd0);
      chk({tag, " idle valid"}, 64'(req_valid), 64'd0);
   endtask

   task automatic launch(input logic rd, input logic wr, input int w, input int h,
                         input logic [31:0] ra, input logic [31:0] wa,
                         input int irw, input int orw);
      read             = rd;
      write            = wr;
      width            = DIM_W'(w);
      height           = DIM_W'(h);
      read_address     = ra;
      write_address    = wa;
      input_row_width  = STRIDE_W'(irw);
      output_row_width = STRIDE_W'(orw);
      start            = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; read = 1'b0; write = 1'b0;
      width = '0; height = '0; read_address = '0; write_address = '0;
      input_row_width = '0; output_row_width = '0; req_ready = 1'b1;
`ifdef FPU_REQ_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      step();
      step();
      chk("rst valid", 64'(req_valid), 64'd0);
      chk("rst we", 64'(req_we), 64'd0);
      chk("rst addr", 64'(req_addr), 64'd0);
      chk("rst busy", 64'(making_request), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      rst = 1'b0;
      step();

      // Read-only 2x2 beats with row stride
      launch(1'b1, 1'b0, 128, 2, 32'h1000, 32'h0, 256, 0);
      expect_req("rd0", 1'b0, 32'h1000);
      expect_req("rd1", 1'b0, 32'h1040);
      expect_req("rd2", 1'b0, 32'h1100);
      expect_req("rd3", 1'b0, 32'h1140);
      expect_done("rd");

      // Read then write per beat
      launch(1'b1, 1'b1, 64, 1, 32'h2000, 32'h8000, 0, 0);
      expect_req("rw0", 1'b0, 32'h2000);
      expect_req("rw1", 1'b1, 32'h8000);
      expect_done("rw");

      // Ceil beats, backpressure, and config changes after launch are ignored
      launch(1'b1, 1'b0, 65, 1, 32'h3000, 32'h0, 0, 0);
      req_ready = 1'b0;
      read_address = 32'hDEAD_0000;
      width = '0;
      for (int i = 0; i < 3; i++) begin
         chk("stall valid", 64'(req_valid), 64'd1);
         chk("stall addr", 64'(req_addr), 64'h3000);
         chk("stall we", 64'(req_we), 64'd0);
         step();
      end
      req_ready = 1'b1;
      expect_req("ceil0", 1'b0, 32'h3000);
      expect_req("ceil1", 1'b0, 32'h3040);
      expect_done("ceil");

      // Degenerate launches go straight to DONE
      launch(1'b1, 1'b0, 64, 0, 32'h4000, 32'h0, 0, 0);
      expect_done("h0");
      launch(1'b1, 1'b0, 0, 1, 32'h4000, 32'h0, 0, 0);
      expect_done("w0");
      launch(1'b0, 1'b0, 64, 1, 32'h4000, 32'h0, 0, 0);
      expect_done("nrw");

      // Start during RUN is ignored
      launch(1'b1, 1'b0, 64, 2, 32'h4000, 32'h0, 32'h100, 0);
      start = 1'b1;
      read_address = 32'h9000;
      height = DIM_W'(1);
      expect_req("ign0", 1'b0, 32'h4000);
      start = 1'b0;
      expect_req("ign1", 1'b0, 32'h4100);
      expect_done("ign");

      // Write-only with output stride
      launch(1'b0, 1'b1, 64, 2, 32'h0, 32'h100, 0, 32'h40);
      expect_req("wo0", 1'b1, 32'h100);
      expect_req("wo1", 1'b1, 32'h140);
      expect_done("wo");

      // Address wraps modulo 2^32
      launch(1'b1, 1'b0, 128, 1, 32'hFFFF_FFC0, 32'h0, 0, 0);
      expect_req("wrap0", 1'b0, 32'hFFFF_FFC0);
      expect_req("wrap1", 1'b0, 32'h0000_0000);
      expect_done("wrap");

      // Reset mid-RUN, then restart from row 0
      launch(1'b1, 1'b0, 128, 2, 32'h5000, 32'h0, 32'h80, 0);
      expect_req("pre0", 1'b0, 32'h5000);
      expect_req("pre1", 1'b0, 32'h5040);
      rst = 1'b1;
      step();
      chk("mrst valid", 64'(req_valid), 64'd0);
      chk("mrst we", 64'(req_we), 64'd0);
      chk("mrst addr", 64'(req_addr), 64'd0);
      chk("mrst busy", 64'(making_request), 64'd0);
      chk("mrst done", 64'(done), 64'd0);
      rst = 1'b0;
      step();
      chk("mrst no done", 64'(done), 64'd0);
      launch(1'b1, 1'b0, 128, 2, 32'h5000, 32'h0, 32'h80, 0);
      expect_req("post0", 1'b0, 32'h5000);
      expect_req("post1", 1'b0, 32'h5040);
      expect_req("post2", 1'b0, 32'h5080);
      expect_req("post3", 1'b0, 32'h50C0);
      expect_done("post");

`ifdef FPU_REQ_SEQ_ABORT_EN
      // 8-request job aborted on the cycle of the 2nd accept
      launch(1'b1, 1'b1, 256, 1, 32'h6000, 32'h7000, 0, 0);
      expect_req("ab0", 1'b0, 32'h6000);
      abort = 1'b1;
      expect_req("ab1", 1'b1, 32'h7000);
      abort = 1'b0;
      expect_done("ab");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_req_seq.md
FPU_REQ_SEQ -- requirements
Module: fpu_req_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; every other parameter and port SHALL be as listed below.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DIM_W, default 17, width/height field width.
REQ-004 Parameter STRIDE_W, default 19, row-stride field width.
REQ-005 Parameter LINE_BYTES, default 64, bytes per memory request (power of two).
REQ-006 Ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 Ports: start  in  1  one-cycle launch pulse; read  in  1  enable read stream; write  in  1  enable write stream.
REQ-008 Ports: width  in  DIM_W  row length in bytes; height  in  DIM_W  row count.
REQ-009 Ports: read_address  in  ADDR_W  read base; write_address  in  ADDR_W  write base; input_row_width  in  STRIDE_W  read stride in bytes; output_row_width  in  STRIDE_W  write stride in bytes.
REQ-010 Ports: req_valid  out  1; req_ready  in  1; req_we  out  1  (1 = write); req_addr  out  ADDR_W.
REQ-011 Ports: making_request  out  1  busy; done  out  1  one-cycle completion pulse.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start with (read|write) and nonzero width and height; RUN->DONE after final accepted request; DONE->IDLE unconditionally.
REQ-013 start SHALL latch all configuration inputs; later input changes SHALL be ignored until IDLE.
REQ-014 start with width=0, height=0, or read=write=0 SHALL go IDLE->DONE, issuing no request.
REQ-015 start while not IDLE SHALL be ignored.
REQ-016 Beats per row SHALL be ceil(width/LINE_BYTES), computed at latch time.
REQ-017 Read address for row r, beat b SHALL be read_address + r*input_row_width + b*LINE_BYTES, modulo 2^ADDR_W; write uses write_address/output_row_width.
REQ-018 Order SHALL be row-major, beat-minor; with read and write both set, each beat SHALL issue read then write before advancing.
REQ-019 req_valid SHALL be high only in RUN; req_addr/req_we SHALL be stable while req_valid && !req_ready.
REQ-020 A request SHALL be accepted on a cycle with req_valid && req_ready; next request SHALL be presented the following cycle (one request per cycle at full throughput).
REQ-021 making_request SHALL be high in RUN and DONE; done SHALL be high only in DONE.
REQ-022 Address arithmetic SHALL use incremental row-base and beat-offset registers, no multiplier.

Reset
REQ-023 rst SHALL force IDLE, req_valid=0, req_we=0, req_addr=0, making_request=0, done=0, all counters 0, in the same cycle edge, including mid-RUN; no done pulse on reset abort.

Configuration
REQ-024 With FPU_REQ_SEQ_ABORT_EN defined, an extra input abort (1 bit) SHALL, in RUN, go to DONE at the next edge where no request is held (req_valid low or accepted that cycle), issuing no further requests.
REQ-025 Without FPU_REQ_SEQ_ABORT_EN, the abort port SHALL not exist and the sequence always runs to completion.

Verification
REQ-026 read only, width=128, height=2, read_address=0x1000, input_row_width=256, ready=1 -> addrs 0x1000,0x1040,0x1100,0x1140, we=0, done 1 cycle after last.
REQ-027 read+write, width=64, height=1, write_address=0x8000 -> read 0x(base) then write 0x8000, then done.
REQ-028 width=65, height=1, read only -> 2 requests (ceil); ready held low 3 cycles -> addr/we stable, no skipped request.
REQ-029 start with height=0 -> no req_valid, done pulse the cycle after IDLE->DONE; start during RUN ignored.
REQ-030 rst asserted mid-RUN -> all outputs 0 next edge, no done; new start then restarts from row 0.
REQ-031 FPU_REQ_SEQ_ABORT_EN: abort after 2nd accept of 8-request job -> exactly 2 requests, done pulse, back to IDLE.
